// File: rtl/jb_iq_agc_gain_ctrl_if.sv
// jb_axi4_stream_if: minimal AXI4-stream tap carrying {Q,I} samples.
interface jb_axi4_stream_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/jb_iq_agc_gain_ctrl.sv
// jb_iq_agc_gain_ctrl: windowed IQ level detector driving a closed-loop (exponent, fraction) gain word.
// Define JB_AGC_PEAK_DET_EN to detect the per-window peak of max(|I|,|Q|) instead of the mean of |I|+|Q|.
module jb_iq_agc_gain_ctrl #(
  parameter int PRECISION = 16,
  parameter int SCALER_BW = 4,
  parameter int WIN_LOG2  = 10,
  parameter int STEP      = 256
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clk_en,
  input  logic                 agc_en,
  input  logic [PRECISION:0]   target_level,
  input  logic [PRECISION-1:0] hyst,
  jb_axi4_stream_if.slave      IFP_dfe_in,
  output logic                 scaler_gain_sign,
  output logic [SCALER_BW-1:0] scaler_gain,
  output logic [PRECISION-1:0] fraction_gain,
  output logic                 gain_update,
  output logic [PRECISION:0]   level_out
);
  localparam int LW = PRECISION + 1;
  localparam int EW = SCALER_BW + 1;
  localparam logic [PRECISION-1:0]  F_ONE  = {1'b1, {(PRECISION-1){1'b0}}};
  localparam logic [PRECISION-1:0]  F_QTR  = {2'b01, {(PRECISION-2){1'b0}}};
  localparam logic signed [EW-1:0]  EMAX   = {1'b0, {SCALER_BW{1'b1}}};
  localparam logic signed [EW-1:0]  EMIN   = -EMAX;
  localparam logic signed [EW-1:0]  E_ONE  = EW'(1);
  localparam logic [LW-1:0]         STEP_W = LW'(STEP);
  localparam logic [0:0]            S_IDLE  = 1'b0;
  localparam logic [0:0]            S_ACCUM = 1'b1;

  typedef struct packed {
    logic signed [EW-1:0] e;
    logic [PRECISION-1:0] f;
  } gain_t;

  logic [0:0]            state_q, state_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]         mean_q, level_q;
  logic [1:0]            vld_pipe;   // [0]=EVAL pending, [1]=UPDATE pending
  logic [1:0]            dir_q;      // {over, under}
  gain_t                 gain_q, gain_d;
  logic                  gupd_q;

  assign IFP_dfe_in.tready = 1'b1;

  logic [PRECISION-1:0] s_i, s_q, abs_i, abs_q;
  assign s_i   = IFP_dfe_in.tdata[PRECISION-1:0];
  assign s_q   = IFP_dfe_in.tdata[2*PRECISION-1:PRECISION];
  // Unsigned P-bit negate keeps |-2^(P-1)| = 2^(P-1) exact.
  assign abs_i = s_i[PRECISION-1] ? -s_i : s_i;
  assign abs_q = s_q[PRECISION-1] ? -s_q : s_q;

`ifdef JB_AGC_PEAK_DET_EN
  localparam int DW = LW;
`else
  localparam int DW = LW + WIN_LOG2;
`endif
  logic [DW-1:0] det_q, det_d, det_run;
  logic [LW-1:0] win_mean;
`ifdef JB_AGC_PEAK_DET_EN
  logic [LW-1:0] pk;
  assign pk       = (abs_i > abs_q) ? {1'b0, abs_i} : {1'b0, abs_q};
  assign det_run  = (pk > det_q) ? pk : det_q;
  assign win_mean = det_run;
`else
  logic [LW-1:0] mag;
  assign mag      = {1'b0, abs_i} + {1'b0, abs_q};
  assign det_run  = det_q + DW'(mag);
  assign win_mean = det_run[DW-1:WIN_LOG2];
`endif

  logic beat, win_end;
  assign beat    = (state_q == S_ACCUM) && agc_en && IFP_dfe_in.tvalid;
  assign win_end = beat && (cnt_q == '1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    det_d   = det_q;
    if (!agc_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      det_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_ACCUM;
    end else if (IFP_dfe_in.tvalid) begin
      cnt_d = cnt_q + WIN_LOG2'(1);
      det_d = win_end ? '0 : det_run;
    end
  end

  // Thresholds are widened by one bit so target+hyst and mean+hyst never wrap.
  logic [LW:0] hi_thr, mean_hy;
  logic        over, under;
  assign hi_thr  = {1'b0, target_level} + {2'b00, hyst};
  assign mean_hy = {1'b0, mean_q} + {2'b00, hyst};
  assign over    = {1'b0, mean_q} > hi_thr;
  assign under   = mean_hy < {1'b0, target_level};

  logic [LW-1:0] f_dn, f_up;
  assign f_dn = {1'b0, gain_q.f} - STEP_W;
  assign f_up = {1'b0, gain_q.f} + STEP_W;

  // Fraction lives in [1/2, 1]; leaving that range renormalizes through the exponent.
  always_comb begin
    gain_d = gain_q;
    if (dir_q[1]) begin
      if (f_dn < {1'b0, F_QTR}) begin
        if (gain_q.e > EMIN) begin
          gain_d.f = {f_dn[PRECISION-2:0], 1'b0};
          gain_d.e = gain_q.e - E_ONE;
        end else begin
          gain_d.f = F_QTR;
        end
      end else begin
        gain_d.f = f_dn[PRECISION-1:0];
      end
    end else if (dir_q[0]) begin
      if (f_up > {1'b0, F_ONE}) begin
        if (gain_q.e < EMAX) begin
          gain_d.f = f_up[PRECISION:1];
          gain_d.e = gain_q.e + E_ONE;
        end else begin
          gain_d.f = F_ONE;
        end
      end else begin
        gain_d.f = f_up[PRECISION-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      det_q    <= '0;
      mean_q   <= '0;
      level_q  <= '0;
      vld_pipe <= '0;
      dir_q    <= '0;
      gain_q   <= '{e: '0, f: F_ONE};
      gupd_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
      vld_pipe <= agc_en ? {vld_pipe[0], win_end} : 2'b00;
      if (win_end)
        mean_q <= win_mean;
      if (vld_pipe[0] && agc_en) begin
        level_q <= mean_q;
        dir_q   <= {over, under};
      end
      gupd_q <= vld_pipe[1] && agc_en && (gain_d != gain_q);
      if (vld_pipe[1] && agc_en)
        gain_q <= gain_d;
    end
  end

  assign scaler_gain_sign = gain_q.e[EW-1];
  assign scaler_gain      = gain_q.e[EW-1] ? SCALER_BW'(-gain_q.e) : SCALER_BW'(gain_q.e);
  assign fraction_gain    = gain_q.f;
  assign gain_update      = gupd_q;
  assign level_out        = level_q;
endmodule

// File: tb/tb_jb_iq_agc_gain_ctrl.sv
// tb_jb_iq_agc_gain_ctrl: directed scenarios plus random traffic against a queue/integer AGC model.
module tb_jb_iq_agc_gain_ctrl;
  localparam int P = 16, SBW = 4, WL2 = 4, WIN = 16, STEPV = 256, HYST = 64;

  logic clk = 1'b0;
  logic resetn, clk_en, agc_en;
  logic [P:0]     target_level;
  logic [P-1:0]   hyst;
  logic           scaler_gain_sign, gain_update;
  logic [SBW-1:0] scaler_gain;
  logic [P-1:0]   fraction_gain;
  logic [P:0]     level_out;

  jb_axi4_stream_if #(.DATA_W(2*P)) s_if ();

  jb_iq_agc_gain_ctrl #(.PRECISION(P), .SCALER_BW(SBW), .WIN_LOG2(WL2), .STEP(STEPV)) dut (
    .clk(clk), .resetn(resetn), .clk_en(clk_en), .agc_en(agc_en),
    .target_level(target_level), .hyst(hyst), .IFP_dfe_in(s_if),
    .scaler_gain_sign(scaler_gain_sign), .scaler_gain(scaler_gain),
    .fraction_gain(fraction_gain), .gain_update(gain_update), .level_out(level_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: window collected in a queue, gain kept as plain integers.
  int m_e, m_f, m_level, m_mean, m_dir;
  bit m_gu, m_armed, p_eval, p_upd;
  int win[$];

  always @(posedge clk) begin : mdl
    int ii, qi, s, ne, nf, t2;
    bit ngu;
    if (!resetn) begin
      m_e = 0; m_f = 32768; m_level = 0; m_mean = 0; m_dir = 0;
      m_gu = 0; m_armed = 0; p_eval = 0; p_upd = 0; win.delete();
    end else if (clk_en) begin
      ngu = 0;
      if (p_upd && agc_en) begin
        ne = m_e; nf = m_f;
        if (m_dir > 0) begin
          t2 = m_f - STEPV;
          if (t2 < 16384) begin
            if (m_e > -15) begin nf = t2 * 2; ne = m_e - 1; end
            else nf = 16384;
          end else nf = t2;
        end else if (m_dir < 0) begin
          t2 = m_f + STEPV;
          if (t2 > 32768) begin
            if (m_e < 15) begin nf = t2 / 2; ne = m_e + 1; end
            else nf = 32768;
          end else nf = t2;
        end
        ngu = (ne != m_e) || (nf != m_f);
        m_e = ne; m_f = nf;
      end
      if (p_eval && agc_en) begin
        m_level = m_mean;
        if (m_mean > int'(target_level) + int'(hyst)) m_dir = 1;
        else if (m_mean < int'(target_level) - int'(hyst)) m_dir = -1;
        else m_dir = 0;
      end
      p_upd  = p_eval && agc_en;
      p_eval = 0;
      if (!agc_en) begin
        m_armed = 0; win.delete();
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (s_if.tvalid) begin
        ii = int'($signed(s_if.tdata[15:0]));
        qi = int'($signed(s_if.tdata[31:16]));
        win.push_back((ii < 0 ? -ii : ii) + (qi < 0 ? -qi : qi));
        if (win.size() == WIN) begin
          s = 0;
          foreach (win[k]) s += win[k];
          m_mean = s / WIN;
          p_eval = 1;
          win.delete();
        end
      end
      m_gu = ngu;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sign",   32'(scaler_gain_sign), 32'(m_e < 0));
      chk("scaler", 32'(scaler_gain),      32'(m_e < 0 ? -m_e : m_e));
      chk("frac",   32'(fraction_gain),    32'(m_f));
      chk("gupd",   32'(gain_update),      32'(m_gu));
      chk("level",  32'(level_out),        32'(m_level));
      chk("tready", 32'(s_if.tready),      32'd1);
    end
  end

  task automatic beat(input bit v, input int i, input int q);
    @(negedge clk);
    s_if.tvalid = v;
    s_if.tdata  = {q[15:0], i[15:0]};
  endtask

  task automatic restart();
    beat(0, 0, 0); agc_en = 1'b0;
    beat(0, 0, 0); agc_en = 1'b1;
    beat(0, 0, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, nvalid, rises, highs, rng, a, b;
    bit seen, prev;
    resetn = 0; clk_en = 1; agc_en = 0; target_level = 1000; hyst = HYST;
    s_if.tvalid = 0; s_if.tdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_sign", 32'(scaler_gain_sign), 0);
    chk("rst_scaler", 32'(scaler_gain), 0);
    chk("rst_frac", 32'(fraction_gain), 32768);
    chk("rst_gupd", 32'(gain_update), 0);
    chk("rst_level", 32'(level_out), 0);
    chk_on = 1;
    resetn = 1; agc_en = 1;

    // Overload: mean 2000 against target 1000.
    for (int n = 0; n < WIN; n++) beat(1, 1000, 1000);
    beat(0, 0, 0); beat(0, 0, 0);
    chk("ovl_level", 32'(level_out), 2000);
    chk("ovl_gupd_early", 32'(gain_update), 0);
    beat(0, 0, 0);
    chk("ovl_gupd", 32'(gain_update), 1);
    chk("ovl_frac", 32'(fraction_gain), 32512);
    chk("ovl_model_frac", 32'(m_f), 32512);
    beat(0, 0, 0);
    chk("ovl_pulse_1cyc", 32'(gain_update), 0);

    // Silence: gain climbs through renormalizations up to e=+15, f=1.0.
    seen = 0; k = 0;
    while (!(scaler_gain == 15 && fraction_gain == 32768) && k < 20000) begin
      beat(1, 0, 0); k++;
      if (!seen && scaler_gain == 1) begin
        seen = 1;
        chk("renorm_up_frac", 32'(fraction_gain), 16512);
        chk("renorm_up_sign", 32'(scaler_gain_sign), 0);
      end
    end
    chk("sat_hi_bound", 32'(k < 20000), 1);
    for (int n = 0; n < 3 * WIN; n++) beat(1, 0, 0);
    chk("sat_hi_scaler", 32'(scaler_gain), 15);
    chk("sat_hi_frac", 32'(fraction_gain), 32768);
    chk("sat_hi_sign", 32'(scaler_gain_sign), 0);

    // Heavy overload: gain walks down to e=-15, f=0.5.
    seen = 0; k = 0;
    while (!(scaler_gain_sign && scaler_gain == 15 && fraction_gain == 16384) && k < 40000) begin
      beat(1, 20000, -20000); k++;
      if (!seen && scaler_gain_sign) begin
        seen = 1;
        chk("renorm_dn_scaler", 32'(scaler_gain), 1);
        chk("renorm_dn_frac", 32'(fraction_gain), 32256);
      end
    end
    chk("sat_lo_bound", 32'(k < 40000), 1);
    for (int n = 0; n < 3 * WIN; n++) beat(1, 20000, 20000);
    chk("sat_lo_frac", 32'(fraction_gain), 16384);
    chk("sat_lo_scaler", 32'(scaler_gain), 15);

    // Deadband: mean equals target, no updates.
    restart();
    target_level = 2000; rises = 0;
    for (int n = 0; n < 3 * WIN + 3; n++) begin
      beat(n < 3 * WIN, 1000, -1000);
      if (gain_update) rises++;
    end
    chk("dband_no_update", 32'(rises), 0);
    chk("dband_level", 32'(level_out), 2000);

    // agc_en drop mid-window, then a fresh gapped window.
    target_level = 1000;
    for (int n = 0; n < 10; n++) beat(1, 300, 300);
    agc_en = 0;
    for (int n = 0; n < 3; n++) beat(1, 300, 300);
    agc_en = 1;
    beat(0, 0, 0);
    nvalid = 0; k = 0;
    while (nvalid < WIN) begin
      k++;
      if (k % 3 == 0) beat(0, 5000, 5000);
      else begin beat(1, 100, -100); nvalid++; end
    end
    beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 0);
    chk("fresh_level", 32'(level_out), 200);
    chk("fresh_gupd", 32'(gain_update), 1);
    chk("fresh_frac", 32'(fraction_gain), 16640);

    // clk_en stall across the UPDATE edge still yields exactly one pulse.
    for (int n = 0; n < WIN; n++) beat(1, 100, 100);
    beat(0, 0, 0); beat(0, 0, 0);
    clk_en = 0; rises = 0; highs = 0; prev = gain_update;
    for (int n = 0; n < 10; n++) begin
      beat(0, 0, 0);
      if (n == 4) clk_en = 1;
      if (gain_update && !prev) rises++;
      prev = gain_update;
    end
    chk("stall_single_pulse", 32'(rises), 1);
    chk("stall_frac", 32'(fraction_gain), 16896);

    // Random traffic, random stalls, enable toggles and a mid-window reset.
    rng = 2000;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        target_level = 17'($urandom_range(300, 4000));
        case ($urandom_range(0, 2))
          0: rng = 300;
          1: rng = 2500;
          default: rng = 32767;
        endcase
      end
      a = $urandom_range(0, rng); if ($urandom_range(0, 1) == 1) a = -a;
      b = $urandom_range(0, rng); if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 49) == 0) a = -32768;
      beat($urandom_range(0, 3) != 0, a, b);
      clk_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) agc_en = ~agc_en;
      resetn = (n != 2100);
    end
    resetn = 1; clk_en = 1;
    beat(0, 0, 0); beat(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
